// File: rtl/player_ctl.sv
// Per-frame player motion controller: samples buttons on each vsync rising edge and
// integrates horizontal steps plus jump/gravity physics for the sprite draw stage.
module player_ctl #(
   parameter int RECT_WIDTH = 48,
   parameter int SCREEN_W   = 800,
   parameter int X_INIT     = 376,
   parameter int GROUND_Y   = 536,
   parameter int H_STEP     = 4,
   parameter int JUMP_V     = 16,
   parameter int VMAX       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       game_en,
   input  logic       restart,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       mirror,
   output logic       airborne,
   output logic       land
);

   localparam int unsigned POS_W   = 10;
   localparam int unsigned VEL_W   = 8;
   localparam int unsigned ARITH_W = 12;

   localparam logic [POS_W-1:0]          X_RST   = POS_W'(X_INIT);
   localparam logic [POS_W-1:0]          X_MAX   = POS_W'(SCREEN_W - RECT_WIDTH);
   localparam logic [POS_W-1:0]          STEP    = POS_W'(H_STEP);
   localparam logic [POS_W-1:0]          Y_GND   = POS_W'(GROUND_Y);
   localparam logic signed [ARITH_W-1:0] Y_GND_S = ARITH_W'(GROUND_Y);
   localparam logic signed [ARITH_W-1:0] V_MAX_S = ARITH_W'(VMAX);
   localparam logic signed [VEL_W-1:0]   V_JUMP  = VEL_W'(-JUMP_V);

   typedef enum logic [1:0] {GROUND, RISE, FALL} state_e;

   state_e                    state_q, state_d;
   logic                      vsync_q;
   logic [POS_W-1:0]          x_q, x_d;
   logic [POS_W-1:0]          y_q, y_d;
   logic signed [VEL_W-1:0]   vel_q, vel_d;
   logic                      mirror_q, mirror_d;
   logic                      air_q, air_d;
   logic                      land_q, land_d;

   logic                      tick_c;
   logic [POS_W:0]            x_right_c;
   logic signed [ARITH_W-1:0] y_ext_c, vel_ext_c, yn_c, vn_raw_c, vn_c;

   assign tick_c = vsync_in & ~vsync_q;

   // Physics is evaluated at 12 bits signed so y + vel and vel + 1 never wrap
   assign y_ext_c   = {{(ARITH_W-POS_W){1'b0}}, y_q};
   assign vel_ext_c = {{(ARITH_W-VEL_W){vel_q[VEL_W-1]}}, vel_q};
   assign yn_c      = y_ext_c + vel_ext_c;
   assign vn_raw_c  = vel_ext_c + 12'sd1;
   assign vn_c      = (vn_raw_c > V_MAX_S) ? V_MAX_S : vn_raw_c;
   assign x_right_c = {1'b0, x_q} + {1'b0, STEP};

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vel_d    = vel_q;
      mirror_d = mirror_q;
      land_d   = 1'b0;

      if (restart) begin
         state_d  = GROUND;
         x_d      = X_RST;
         y_d      = Y_GND;
         vel_d    = '0;
         mirror_d = 1'b0;
      end else if (tick_c && game_en) begin
         if (btn_left && !btn_right) begin
            x_d      = (x_q < STEP) ? '0 : x_q - STEP;
            mirror_d = 1'b1;
         end else if (btn_right && !btn_left) begin
            x_d      = (x_right_c > {1'b0, X_MAX}) ? X_MAX : x_right_c[POS_W-1:0];
            mirror_d = 1'b0;
         end

         case (state_q)
            GROUND: begin
               if (btn_jump) begin
                  vel_d   = V_JUMP;
                  state_d = RISE;
               end
            end
            default: begin
               if (yn_c >= Y_GND_S) begin
                  y_d     = Y_GND;
                  vel_d   = '0;
                  state_d = GROUND;
                  land_d  = 1'b1;
               end else if (yn_c < 12'sd0) begin
                  y_d     = '0;
                  vel_d   = '0;
                  state_d = FALL;
               end else begin
                  y_d     = yn_c[POS_W-1:0];
                  vel_d   = vn_c[VEL_W-1:0];
                  state_d = (vn_c < 12'sd0) ? RISE : FALL;
               end
            end
         endcase
      end

      air_d = (state_d != GROUND);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= GROUND;
         vsync_q  <= 1'b0;
         x_q      <= X_RST;
         y_q      <= Y_GND;
         vel_q    <= '0;
         mirror_q <= 1'b0;
         air_q    <= 1'b0;
         land_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vsync_q  <= vsync_in;
         x_q      <= x_d;
         y_q      <= y_d;
         vel_q    <= vel_d;
         mirror_q <= mirror_d;
         air_q    <= air_d;
         land_q   <= land_d;
      end
   end

   assign xpos     = x_q;
   assign ypos     = y_q;
   assign mirror   = mirror_q;
   assign airborne = air_q;
   assign land     = land_q;

endmodule

// File: tb/tb_player_ctl.sv
// Bench for player_ctl: table-driven frame vectors plus hand-written jump, clamp,
// restart and async-reset sequences, checked through an expected-value queue.
module tb_player_ctl;

   localparam int X0 = 376;
   localparam int GY = 536;
   localparam int XMAX = 752;

   typedef struct { int x; int y; logic m; logic a; logic l; } exp_t;
   typedef struct { logic l; logic r; logic j; logic ge; int x; int y; logic m; logic a; } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync_in = 1'b0;
   logic       game_en = 1'b1;
   logic       restart = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_jump = 1'b0;
   logic [9:0] xpos, ypos;
   logic       mirror, airborne, land;

   player_ctl dut (
      .clk(clk), .rst(rst), .vsync_in(vsync_in), .game_en(game_en), .restart(restart),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .xpos(xpos), .ypos(ypos), .mirror(mirror), .airborne(airborne), .land(land)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   mx, my, mvel, mstate;
   logic mm;
   int   snap_x, snap_y, snap_a, snap_l;
   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mx = X0; my = GY; mvel = 0; mstate = 0; mm = 1'b0;
   endtask

   // Reference physics: one frame tick as seen by the player
   task automatic model_step(input logic l, r, j, ge, rs, output exp_t e);
      int yn, vn;
      e.l = 1'b0;
      if (rs) model_reset();
      else if (ge) begin
         if (l && !r) begin mx = (mx - 4 < 0) ? 0 : mx - 4; mm = 1'b1; end
         else if (r && !l) begin mx = (mx + 4 > XMAX) ? XMAX : mx + 4; mm = 1'b0; end
         if (mstate == 0) begin
            if (j) begin mvel = -16; mstate = 1; end
         end else begin
            yn = my + mvel;
            vn = (mvel + 1 > 16) ? 16 : mvel + 1;
            if (yn >= GY) begin my = GY; mvel = 0; mstate = 0; e.l = 1'b1; end
            else if (yn < 0) begin my = 0; mvel = 0; mstate = 2; end
            else begin my = yn; mvel = vn; mstate = (vn < 0) ? 1 : 2; end
         end
      end
      e.x = mx; e.y = my; e.m = mm; e.a = (mstate != 0);
   endtask

   // One frame: raise vsync with the given inputs, compare after the update edge
   task automatic frame(input logic l, r, j, ge, rs, input string tag,
                        input logic use_tbl, input exp_t tbl_e);
      exp_t e, got;
      @(negedge clk);
      btn_left = l; btn_right = r; btn_jump = j; game_en = ge; restart = rs; vsync_in = 1'b1;
      model_step(l, r, j, ge, rs, e);
      sb_q.push_back(use_tbl ? tbl_e : e);
      @(posedge clk); #1;
      restart = 1'b0;
      snap_x = int'(xpos); snap_y = int'(ypos); snap_a = int'(airborne); snap_l = int'(land);
      if (sb_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s_queue: got empty scoreboard, expected one entry", tag);
      end else begin
         got = sb_q.pop_front();
         chk({tag, "_x"}, int'(xpos), got.x);
         chk({tag, "_y"}, int'(ypos), got.y);
         chk({tag, "_mirror"}, int'(mirror), int'(got.m));
         chk({tag, "_air"}, int'(airborne), int'(got.a));
         chk({tag, "_land"}, int'(land), int'(got.l));
      end
      @(posedge clk); #1;
      chk({tag, "_land_after"}, int'(land), 0);
      chk({tag, "_hold_y"}, int'(ypos), snap_y);
      @(negedge clk);
      vsync_in = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; game_en = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic mframe(input logic l, r, j, ge, rs, input string tag);
      exp_t dummy;
      dummy = '{0, 0, 1'b0, 1'b0, 1'b0};
      frame(l, r, j, ge, rs, tag, 1'b0, dummy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      exp_t te;
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 380, GY, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 384, GY, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 388, GY, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 388, GY, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 384, GY, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 384, GY, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 384, GY, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 384, GY, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 388, GY, 1'b0, 1'b0};

      #12;
      chk("reset_x", int'(xpos), X0);
      chk("reset_y", int'(ypos), GY);
      chk("reset_mirror", int'(mirror), 0);
      chk("reset_air", int'(airborne), 0);
      chk("reset_land", int'(land), 0);
      model_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         te = '{tbl[i].x, tbl[i].y, tbl[i].m, tbl[i].a, 1'b0};
         frame(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].ge, 1'b0, $sformatf("tbl%0d", i), 1'b1, te);
      end

      // Press entirely between ticks is lost
      @(negedge clk); btn_right = 1'b1;
      repeat (3) @(negedge clk);
      btn_right = 1'b0;
      mframe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "between");
      chk("between_x_const", snap_x, 388);

      for (int i = 0; i < 200 && mx > 0; i++) mframe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "left");
      mframe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "left_clamp");
      chk("left_clamp_const", snap_x, 0);
      for (int i = 0; i < 200 && mx < XMAX; i++) mframe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "right");
      mframe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "right_clamp");
      mframe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "right_clamp2");
      chk("right_clamp_const", snap_x, XMAX);

      // Single jump press, then released
      mframe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "jump0");
      chk("jump0_y", snap_y, GY);
      for (int k = 1; k <= 33; k++) begin
         mframe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("jump%0d", k));
         if (k == 1) begin chk("jump_t1_y", snap_y, 520); chk("jump_t1_air", snap_a, 1); end
         if (k == 16 || k == 17) chk($sformatf("jump_t%0d_apex", k), snap_y, 400);
         if (k == 33) begin
            chk("jump_t33_y", snap_y, GY);
            chk("jump_t33_land", snap_l, 1);
            chk("jump_t33_air", snap_a, 0);
         end
      end

      // Held jump: land without jumping, relaunch on the next tick
      mframe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "hold0");
      for (int k = 1; k <= 35; k++) begin
         mframe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("hold%0d", k));
         if (k == 33) begin chk("hold_t33_land", snap_l, 1); chk("hold_t33_air", snap_a, 0); end
         if (k == 34) begin chk("hold_t34_y", snap_y, GY); chk("hold_t34_air", snap_a, 1); end
         if (k == 35) chk("hold_t35_y", snap_y, 520);
      end

      for (int k = 0; k < 5; k++) mframe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("frozen%0d", k));
      chk("frozen_y", snap_y, 520);
      chk("frozen_air", snap_a, 1);

      mframe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_restart");
      mframe(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "restart");
      chk("restart_x", snap_x, X0);
      chk("restart_y", snap_y, GY);
      chk("restart_air", snap_a, 0);
      chk("restart_land", snap_l, 0);

      // Asynchronous reset mid-jump, released with vsync already high
      mframe(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "ar_jump");
      mframe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ar_rise");
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("async_x", int'(xpos), X0);
      chk("async_y", int'(ypos), GY);
      chk("async_mirror", int'(mirror), 0);
      chk("async_air", int'(airborne), 0);
      model_reset();
      @(negedge clk); vsync_in = 1'b1; btn_right = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("release_tick_x", int'(xpos), 380);
      chk("release_tick_y", int'(ypos), GY);
      @(posedge clk); #1;
      chk("release_once_x", int'(xpos), 380);
      @(negedge clk); vsync_in = 1'b0; btn_right = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
